// File: rtl/empu_pkg.sv
// Shared definitions for the GPIO/UART controller: command bytes, FSM states,
// reply queue layout and baud divider calculation.
package empu_pkg;

    localparam logic [7:0] CMD_W = 8'h57;
    localparam logic [7:0] CMD_E = 8'h45;
    localparam logic [7:0] CMD_R = 8'h52;
    localparam logic [7:0] RSP_K = 8'h4B;
    localparam logic [7:0] RSP_Q = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GET_HI,
        ST_GET_LO,
        ST_REPLY
    } cmd_state_e;

    typedef enum logic {
        TGT_OUT,
        TGT_OEN
    } tgt_e;

    // Up to two reply bytes; b0 is always the next one to send.
    typedef struct packed {
        logic [1:0] cnt;
        logic [7:0] b0;
        logic [7:0] b1;
    } rsp_t;

    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/empu_gpio_uart_if.sv
// Byte-level handshake between the command logic (master) and the UART PHY (slave).
interface empu_gpio_uart_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_busy;

    modport master (input rx_valid, rx_data, tx_busy, output tx_start, tx_data);
    modport slave  (output rx_valid, rx_data, tx_busy, input tx_start, tx_data);
endinterface

// File: rtl/empu_uart_phy.sv
// 8N1 UART receiver and transmitter sharing one bit period of DIV clocks.
// rxd must already be synchronised to clk.
module empu_uart_phy #(
    parameter int unsigned DIV = 468
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    output logic              txd,
    empu_gpio_uart_if.slave   bus
);

    localparam int unsigned     CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0]   FULL = CW'(DIV - 1);
    localparam logic [CW-1:0]   HALF = CW'(DIV / 2 - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

    rx_state_e     rx_st_q, rx_st_d;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_sh_q, rx_sh_d;
    logic          rx_vld_q, rx_vld_d;
    logic          rx_prev_q;

    always_comb begin
        rx_st_d  = rx_st_q;
        rx_cnt_d = rx_cnt_q;
        rx_bit_d = rx_bit_q;
        rx_sh_d  = rx_sh_q;
        rx_vld_d = 1'b0;
        if (rx_st_q != RX_IDLE) rx_cnt_d = rx_cnt_q - 1'b1;
        case (rx_st_q)
            RX_IDLE: if (rx_prev_q && !rxd) begin
                rx_st_d  = RX_START;
                rx_cnt_d = HALF;
            end
            // Mid-start re-check rejects glitches shorter than half a bit.
            RX_START: if (rx_cnt_q == '0) begin
                if (rxd) rx_st_d = RX_IDLE;
                else begin
                    rx_st_d  = RX_DATA;
                    rx_cnt_d = FULL;
                    rx_bit_d = '0;
                end
            end
            RX_DATA: if (rx_cnt_q == '0) begin
                rx_sh_d  = {rxd, rx_sh_q[7:1]};
                rx_cnt_d = FULL;
                rx_bit_d = rx_bit_q + 3'd1;
                if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
            end
            RX_STOP: if (rx_cnt_q == '0) begin
                rx_st_d  = RX_IDLE;
                rx_vld_d = rxd;
            end
            default: rx_st_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_st_q   <= RX_IDLE;
            rx_cnt_q  <= '0;
            rx_bit_q  <= '0;
            rx_sh_q   <= '0;
            rx_vld_q  <= 1'b0;
            rx_prev_q <= 1'b1;
        end else begin
            rx_st_q   <= rx_st_d;
            rx_cnt_q  <= rx_cnt_d;
            rx_bit_q  <= rx_bit_d;
            rx_sh_q   <= rx_sh_d;
            rx_vld_q  <= rx_vld_d;
            rx_prev_q <= rxd;
        end
    end

    assign bus.rx_valid = rx_vld_q;
    assign bus.rx_data  = rx_sh_q;

    logic          tx_busy_q, tx_busy_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic [3:0]    tx_left_q, tx_left_d;
    logic [8:0]    tx_sh_q, tx_sh_d;
    logic          txd_q, txd_d;
    logic          tx_done, tx_busy;

    // Last cycle of the stop bit counts as free so the next frame follows without a gap.
    assign tx_done     = tx_busy_q && (tx_cnt_q == '0) && (tx_left_q == '0);
    assign tx_busy     = tx_busy_q && !tx_done;
    assign bus.tx_busy = tx_busy;

    always_comb begin
        tx_busy_d = tx_busy_q;
        tx_cnt_d  = tx_cnt_q;
        tx_left_d = tx_left_q;
        tx_sh_d   = tx_sh_q;
        txd_d     = txd_q;
        if (tx_busy_q) begin
            tx_cnt_d = tx_cnt_q - 1'b1;
            if (tx_cnt_q == '0) begin
                if (tx_left_q == '0) tx_busy_d = 1'b0;
                else begin
                    txd_d     = tx_sh_q[0];
                    tx_sh_d   = {1'b1, tx_sh_q[8:1]};
                    tx_left_d = tx_left_q - 4'd1;
                    tx_cnt_d  = FULL;
                end
            end
        end
        if (bus.tx_start && !tx_busy) begin
            tx_busy_d = 1'b1;
            txd_d     = 1'b0;
            tx_sh_d   = {1'b1, bus.tx_data};
            tx_left_d = 4'd9;
            tx_cnt_d  = FULL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_q <= 1'b0;
            tx_cnt_q  <= '0;
            tx_left_q <= '0;
            tx_sh_q   <= '1;
            txd_q     <= 1'b1;
        end else begin
            tx_busy_q <= tx_busy_d;
            tx_cnt_q  <= tx_cnt_d;
            tx_left_q <= tx_left_d;
            tx_sh_q   <= tx_sh_d;
            txd_q     <= txd_d;
        end
    end

    assign txd = txd_q;

endmodule

// File: rtl/empu_gpio_uart.sv
// GPIO port controlled by byte commands over UART0: W/E write outputs/enables,
// R reads synchronised inputs. Holds synchronisers, command FSM and GPIO registers.
module empu_gpio_uart
    import empu_pkg::*;
#(
    parameter int unsigned CLK_HZ = 54_000_000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic        sys_clk,
    input  logic        reset_n,
    input  logic [15:0] gpioin,
    output logic [15:0] gpioout,
    output logic [15:0] gpioouten,
    input  logic        uart0_rxd,
    output logic        uart0_txd
);

    localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);

    // Assert asynchronously, release two clocks later.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= '0;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    logic [1:0]  rxd_sync_q;
    logic [15:0] gpio_s1_q, gpio_s2_q;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd_sync_q <= 2'b11;
            gpio_s1_q  <= '0;
            gpio_s2_q  <= '0;
        end else begin
            rxd_sync_q <= {rxd_sync_q[0], uart0_rxd};
            gpio_s1_q  <= gpioin;
            gpio_s2_q  <= gpio_s1_q;
        end
    end

    empu_gpio_uart_if u_if ();

    empu_uart_phy #(.DIV(DIV)) u_phy (
        .clk   (sys_clk),
        .rst_n (rst_n),
        .rxd   (rxd_sync_q[1]),
        .txd   (uart0_txd),
        .bus   (u_if)
    );

    cmd_state_e  st_q;
    tgt_e        tgt_q;
    logic [7:0]  hi_q;
    rsp_t        rsp_q;
    logic [15:0] out_q, oen_q;

    assign u_if.tx_start = (st_q == ST_REPLY) && (rsp_q.cnt != 2'd0) && !u_if.tx_busy;
    assign u_if.tx_data  = rsp_q.b0;

    // Bytes arriving while in ST_REPLY are simply never looked at.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q  <= ST_IDLE;
            tgt_q <= TGT_OUT;
            hi_q  <= '0;
            rsp_q <= '0;
            out_q <= 16'h0000;
            oen_q <= 16'h0001;
        end else begin
            case (st_q)
                ST_IDLE: if (u_if.rx_valid) begin
                    case (u_if.rx_data)
                        CMD_W: begin st_q <= ST_GET_HI; tgt_q <= TGT_OUT; end
                        CMD_E: begin st_q <= ST_GET_HI; tgt_q <= TGT_OEN; end
                        CMD_R: begin
                            st_q  <= ST_REPLY;
                            rsp_q <= '{cnt: 2'd2, b0: gpio_s2_q[15:8], b1: gpio_s2_q[7:0]};
                        end
                        default: begin
                            st_q  <= ST_REPLY;
                            rsp_q <= '{cnt: 2'd1, b0: RSP_Q, b1: 8'h00};
                        end
                    endcase
                end
                ST_GET_HI: if (u_if.rx_valid) begin
                    hi_q <= u_if.rx_data;
                    st_q <= ST_GET_LO;
                end
                ST_GET_LO: if (u_if.rx_valid) begin
                    if (tgt_q == TGT_OUT) out_q <= {hi_q, u_if.rx_data};
                    else                  oen_q <= {hi_q, u_if.rx_data};
                    rsp_q <= '{cnt: 2'd1, b0: RSP_K, b1: 8'h00};
                    st_q  <= ST_REPLY;
                end
                ST_REPLY: begin
                    if (u_if.tx_start) begin
                        rsp_q.cnt <= rsp_q.cnt - 2'd1;
                        rsp_q.b0  <= rsp_q.b1;
                    end else if (rsp_q.cnt == 2'd0 && !u_if.tx_busy) begin
                        st_q <= ST_IDLE;
                    end
                end
                default: st_q <= ST_IDLE;
            endcase
        end
    end

    assign gpioout   = out_q;
    assign gpioouten = oen_q;

endmodule

// File: tb/tb_empu_gpio_uart.sv
// Directed bench for empu_gpio_uart: host commands driven on rxd, replies decoded from txd.
module tb_empu_gpio_uart;

    localparam int unsigned CLK_HZ = 160;
    localparam int unsigned BAUD   = 10;
    localparam int unsigned DIV    = 16;

    logic        sys_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] gpioin  = 16'h0000;
    logic [15:0] gpioout, gpioouten;
    logic        uart0_rxd = 1'b1;
    logic        uart0_txd;

    empu_gpio_uart #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .sys_clk   (sys_clk),
        .reset_n   (reset_n),
        .gpioin    (gpioin),
        .gpioout   (gpioout),
        .gpioouten (gpioouten),
        .uart0_rxd (uart0_rxd),
        .uart0_txd (uart0_txd)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;
    int last_start;

    always @(posedge sys_clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] data;
        bit         frame_ok;
        int         t_start;
    } rx_frame_t;

    rx_frame_t rx_q[$];

    // Host-side receiver: mid-bit sampling, start/stop levels checked.
    initial begin : mon
        rx_frame_t f;
        forever begin
            @(negedge sys_clk);
            if (uart0_txd === 1'b0) begin
                f.t_start  = cyc;
                f.frame_ok = 1'b1;
                f.data     = '0;
                repeat (DIV / 2) @(negedge sys_clk);
                if (uart0_txd !== 1'b0) f.frame_ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge sys_clk);
                    f.data[i] = uart0_txd;
                end
                repeat (DIV) @(negedge sys_clk);
                if (uart0_txd !== 1'b1) f.frame_ok = 1'b0;
                rx_q.push_back(f);
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        logic [9:0] fr;
        fr = {stop, b, 1'b0};
        @(negedge sys_clk);
        for (int i = 0; i < 10; i++) begin
            uart0_rxd = fr[i];
            repeat (DIV) @(negedge sys_clk);
        end
        uart0_rxd = 1'b1;
    endtask

    task automatic expect_rsp(input string tag, input logic [7:0] exp);
        rx_frame_t f;
        int t;
        t = 0;
        while (rx_q.size() == 0 && t < 25 * DIV) begin
            @(negedge sys_clk);
            t++;
        end
        if (rx_q.size() == 0) begin
            chk({tag, " timeout"}, 32'd0, 32'd1);
        end else begin
            f = rx_q.pop_front();
            chk(tag, f.data, exp);
            chk({tag, " framing"}, f.frame_ok, 1);
            last_start = f.t_start;
        end
    endtask

    task automatic expect_silence(input string tag);
        repeat (14 * DIV) @(negedge sys_clk);
        chk(tag, rx_q.size(), 0);
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int s1, t;

        repeat (4) @(negedge sys_clk);
        chk("rst gpioout", gpioout, 16'h0000);
        chk("rst gpioouten", gpioouten, 16'h0001);
        chk("rst txd", uart0_txd, 1'b1);
        reset_n = 1'b1;
        repeat (6) @(negedge sys_clk);

        // Write outputs; update must land inside the last frame, after its stop sample.
        send_byte(8'h57);
        send_byte(8'hA5);
        fork
            send_byte(8'h3C);
            begin
                repeat (9 * DIV) @(negedge sys_clk);
                chk("out before stop", gpioout, 16'h0000);
            end
        join
        chk("out after W", gpioout, 16'hA53C);
        expect_rsp("W reply", 8'h4B);

        send_byte(8'h45); send_byte(8'hFF); send_byte(8'h00);
        chk("oen after E", gpioouten, 16'hFF00);
        chk("out kept after E", gpioout, 16'hA53C);
        expect_rsp("E reply", 8'h4B);
        send_byte(8'h57); send_byte(8'h12); send_byte(8'h34);
        chk("out 1234", gpioout, 16'h1234);
        expect_rsp("W2 reply", 8'h4B);

        // Read with two-byte back-to-back reply.
        gpioin = 16'h0002;
        send_byte(8'h52);
        expect_rsp("R hi", 8'h00);
        s1 = last_start;
        expect_rsp("R lo", 8'h02);
        chk("R gap", last_start - s1, 10 * DIV);

        send_byte(8'h00);
        expect_rsp("bad cmd", 8'h3F);
        chk("out after bad", gpioout, 16'h1234);
        chk("oen after bad", gpioouten, 16'hFF00);

        // Framing error must not even start a command.
        send_byte(8'h57, 1'b0);
        expect_silence("ferr no reply");
        send_byte(8'h00);
        expect_rsp("ferr idle", 8'h3F);

        @(negedge sys_clk);
        uart0_rxd = 1'b0;
        repeat (3) @(negedge sys_clk);
        uart0_rxd = 1'b1;
        expect_silence("glitch no reply");

        // Command sent while a reply is in flight is dropped.
        gpioin = 16'h8001;
        send_byte(8'h52);
        send_byte(8'h57);
        expect_rsp("ovl hi", 8'h80);
        expect_rsp("ovl lo", 8'h01);
        send_byte(8'h57); send_byte(8'h00); send_byte(8'h01);
        expect_rsp("ovl W reply", 8'h4B);
        chk("ovl out", gpioout, 16'h0001);
        chk("ovl oen", gpioouten, 16'hFF00);

        // Asynchronous reset in the middle of a reply frame.
        send_byte(8'h00);
        t = 0;
        while (uart0_txd !== 1'b0 && t < 25 * DIV) begin
            @(negedge sys_clk);
            t++;
        end
        chk("reply started", uart0_txd, 1'b0);
        repeat (DIV / 2) @(negedge sys_clk);
        #2 reset_n = 1'b0;
        #1;
        chk("async rst gpioout", gpioout, 16'h0000);
        chk("async rst oen", gpioouten, 16'h0001);
        chk("async rst txd", uart0_txd, 1'b1);
        repeat (3) @(negedge sys_clk);
        reset_n = 1'b1;
        repeat (14 * DIV) @(negedge sys_clk);
        rx_q.delete();

        send_byte(8'h57); send_byte(8'h55); send_byte(8'hAA);
        expect_rsp("post rst reply", 8'h4B);
        chk("post rst out", gpioout, 16'h55AA);
        chk("post rst oen", gpioouten, 16'h0001);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
